mc_mem_unit: RTL and testbench

Parametrised unified instruction/data memory unit for the multicycle MIPS core. It holds PC, IR and MDR, and adds byte/halfword/word accesses with sign/zero extension and configurable wait states through a req/done handshake. Misaligned accesses are detected. Storage is a big-endian byte array. Sits between the control FSM and the ALU datapath; the control FSM stalls on mem_busy.

---
 rtl/mc_mem_pkg.sv | 35 +++
 rtl/mc_mem_array.sv | 44 ++++
 rtl/mc_mem_unit.sv | 176 +++++++++++++++++
 tb/tb_mc_mem_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mc_mem_pkg.sv
// Shared encodings and helpers for the multicycle MIPS memory unit.
package mc_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [1:0] mem_state_t;
    localparam mem_state_t ST_IDLE   = 2'b00;
    localparam mem_state_t ST_WAIT   = 2'b01;
    localparam mem_state_t ST_ACCESS = 2'b10;

    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

    // raw holds the selected lane right-justified; the reserved size behaves as word
    function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sgn,
                                                input logic [31:0] raw);
        logic [31:0] ext;
        case (size)
            SZ_BYTE: ext = {{24{sgn & raw[7]}}, raw[7:0]};
            SZ_HALF: ext = {{16{sgn & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/mc_mem_array.sv
// Big-endian byte array: synchronous byte/half/word write, combinational aligned word read.
module mc_mem_array
    import mc_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    localparam int AW = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    // Write addresses arrive already aligned, so lane offsets are plain bit substitutions
    always_ff @(posedge clk) begin
        if (we) begin
            case (size)
                SZ_BYTE: mem[waddr] <= wdata[7:0];
                SZ_HALF: begin
                    mem[{waddr[AW-1:1], 1'b0}] <= wdata[15:8];
                    mem[{waddr[AW-1:1], 1'b1}] <= wdata[7:0];
                end
                default: begin
                    mem[{waddr[AW-1:2], 2'b00}] <= wdata[31:24];
                    mem[{waddr[AW-1:2], 2'b01}] <= wdata[23:16];
                    mem[{waddr[AW-1:2], 2'b10}] <= wdata[15:8];
                    mem[{waddr[AW-1:2], 2'b11}] <= wdata[7:0];
                end
            endcase
        end
    end

    // Word read at the enclosing aligned address, most significant byte first
    always_comb begin
        rdata = {mem[{raddr[AW-1:2], 2'b00}], mem[{raddr[AW-1:2], 2'b01}],
                 mem[{raddr[AW-1:2], 2'b10}], mem[{raddr[AW-1:2], 2'b11}]};
    end

endmodule

// File: rtl/mc_mem_unit.sv
// Unified I/D memory unit with PC/IR/MDR, wait states and req/done handshake.
// Build option: define MISALIGN_TRAP_EN to report and suppress misaligned accesses.
module mc_mem_unit
    import mc_mem_pkg::*;
#(
    parameter int          DEPTH_BYTES = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic        iord,
    input  logic        ir_we,
    input  logic [31:0] alu_out,
    input  logic [31:0] wdata,
    input  logic        pc_we,
    input  logic [31:0] pc_next,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        misalign,
    output logic [31:0] ir,
    output logic [31:0] mdr,
    output logic [31:0] pc
);

    localparam int         AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    mem_state_t    state_r, state_nx_s;
    logic [3:0]    cnt_r, cnt_nx_s;
    logic [AW-1:0] addr_r, eff_addr_s;
    logic          we_r, sgn_r, irwe_r;
    logic [1:0]    size_r;
    logic [31:0]   wdata_r, pc_r, ir_r, mdr_r, rdata_s, lane_s, addr_in_s;
    logic          busy_r, done_r, mis_r, aligned_s, chk_aligned_s, do_access_s;

    assign addr_in_s = iord ? alu_out : pc_r;

    // Effective address and alignment of the captured access; also check the
    // request being captured so the misalign pulse can line up with mem_done
    always_comb begin
        eff_addr_s = addr_r;
`ifdef MISALIGN_TRAP_EN
        aligned_s     = addr_aligned(size_r, addr_r[1:0]);
        chk_aligned_s = (state_r == ST_IDLE) ? addr_aligned(mem_size, addr_in_s[1:0]) : aligned_s;
`else
        aligned_s     = 1'b1;
        chk_aligned_s = 1'b1;
        case (size_r)
            SZ_BYTE: eff_addr_s = addr_r;
            SZ_HALF: eff_addr_s[0] = 1'b0;
            default: eff_addr_s[1:0] = 2'b00;
        endcase
`endif
    end

    mc_mem_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
        .clk   (clk),
        .we    (do_access_s & we_r),
        .size  (size_r),
        .waddr (eff_addr_s),
        .wdata (wdata_r),
        .raddr (eff_addr_s),
        .rdata (rdata_s)
    );

    // Right-justify the addressed byte/half lane of the read word
    always_comb begin
        lane_s = 32'h0000_0000;
        case (size_r)
            SZ_BYTE: begin
                case (eff_addr_s[1:0])
                    2'b00:   lane_s = {24'h00_0000, rdata_s[31:24]};
                    2'b01:   lane_s = {24'h00_0000, rdata_s[23:16]};
                    2'b10:   lane_s = {24'h00_0000, rdata_s[15:8]};
                    default: lane_s = {24'h00_0000, rdata_s[7:0]};
                endcase
            end
            SZ_HALF: lane_s = eff_addr_s[1] ? {16'h0000, rdata_s[15:0]} : {16'h0000, rdata_s[31:16]};
            default: lane_s = rdata_s;
        endcase
    end

    // Next-state and wait counter
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nx_s = ST_WAIT;
                        cnt_nx_s   = WAIT_LOAD;
                    end else begin
                        state_nx_s = ST_ACCESS;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = ST_ACCESS;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    assign do_access_s = (state_r == ST_ACCESS) & aligned_s;

    // FSM, handshake flags and request capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mis_r   <= 1'b0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            size_r  <= SZ_BYTE;
            sgn_r   <= 1'b0;
            irwe_r  <= 1'b0;
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_nx_s == ST_ACCESS);
            mis_r   <= (state_nx_s == ST_ACCESS) & ~chk_aligned_s;
            if ((state_r == ST_IDLE) && mem_req) begin
                addr_r  <= addr_in_s[AW-1:0];
                we_r    <= mem_we;
                size_r  <= mem_size;
                sgn_r   <= mem_signed;
                irwe_r  <= ir_we;
                wdata_r <= wdata;
            end
        end
    end

    // Architectural registers; PC updates are independent of the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r  <= RESET_PC;
            ir_r  <= 32'h0000_0000;
            mdr_r <= 32'h0000_0000;
        end else begin
            if (pc_we) begin
                pc_r <= pc_next;
            end
            if (do_access_s && !we_r) begin
                mdr_r <= extend_load(size_r, sgn_r, lane_s);
                if (irwe_r) begin
                    ir_r <= rdata_s;
                end
            end
        end
    end

    assign mem_busy = busy_r;
    assign mem_done = done_r;
    assign misalign = mis_r;
    assign ir       = ir_r;
    assign mdr      = mdr_r;
    assign pc       = pc_r;

endmodule

// File: tb/tb_mc_mem_unit.sv
// Directed self-checking bench for mc_mem_unit (DEPTH_BYTES=256, WAIT_CYCLES=2, RESET_PC=0).
module tb_mc_mem_unit;
    import mc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req = 1'b0, mem_we = 1'b0, mem_signed = 1'b0, iord = 1'b0, ir_we = 1'b0, pc_we = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] alu_out = 32'h0, wdata = 32'h0, pc_next = 32'h0;
    logic        mem_busy, mem_done, misalign;
    logic [31:0] ir, mdr, pc;

    int n_vec = 0;
    int n_bad = 0;

    mc_mem_unit #(.DEPTH_BYTES(256), .WAIT_CYCLES(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_signed(mem_signed), .iord(iord), .ir_we(ir_we), .alu_out(alu_out), .wdata(wdata),
        .pc_we(pc_we), .pc_next(pc_next), .mem_busy(mem_busy), .mem_done(mem_done),
        .misalign(misalign), .ir(ir), .mdr(mdr), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One access; the address/data inputs are scrambled after req to show they are captured
    task automatic xfer(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                        input logic sel, input logic irw, input logic [31:0] addr, input logic [31:0] wd,
                        output int busy_n, output logic mis);
        int lat;
        @(negedge clk);
        mem_we = we; mem_size = sz; mem_signed = sgn; iord = sel; ir_we = irw;
        alu_out = addr; wdata = wd; mem_req = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b0; alu_out = 32'hFFFF_FFFC; wdata = 32'h0; mem_size = 2'b00; mem_we = ~we; ir_we = 1'b0;
        lat = 1; busy_n = 0;
        while (!mem_done && lat < 40) begin
            if (mem_busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (mem_busy) busy_n++;
        mis = misalign;
        check_val({tag, "_lat"}, 32'(lat), 32'd3);
        @(posedge clk); #1;
        if (mem_busy) busy_n++;
    endtask

    initial begin
        int   bn, dones, lat;
        logic mis;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pc",   pc,  32'h0);
        check_val("rst_ir",   ir,  32'h0);
        check_val("rst_mdr",  mdr, 32'h0);
        check_val("rst_flags", {29'b0, mem_busy, mem_done, misalign}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Fetch path
        xfer("st0", 1'b1, SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0043_0804, bn, mis);
        check_val("st_keeps_mdr", mdr, 32'h0);
        xfer("fetch", 1'b0, SZ_WORD, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, bn, mis);
        check_val("fetch_busy", 32'(bn), 32'd3);
        check_val("fetch_ir",   ir,  32'h0043_0804);
        check_val("fetch_mdr",  mdr, 32'h0043_0804);

        // Sub-word loads with extension
        xfer("st10", 1'b1, SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, bn, mis);
        xfer("lb11s", 1'b0, SZ_BYTE, 1'b1, 1'b1, 1'b0, 32'h11, 32'h0, bn, mis);
        check_val("lb11s", mdr, 32'hFFFF_FFAD);
        xfer("lb11u", 1'b0, SZ_BYTE, 1'b0, 1'b1, 1'b0, 32'h11, 32'h0, bn, mis);
        check_val("lb11u", mdr, 32'h0000_00AD);
        xfer("lb13u", 1'b0, SZ_BYTE, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, bn, mis);
        check_val("lb13u", mdr, 32'h0000_00EF);
        xfer("lh10u", 1'b0, SZ_HALF, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, bn, mis);
        check_val("lh10u", mdr, 32'h0000_DEAD);
        xfer("lh12s", 1'b0, SZ_HALF, 1'b1, 1'b1, 1'b0, 32'h12, 32'h0, bn, mis);
        check_val("lh12s", mdr, 32'hFFFF_BEEF);
        check_val("ir_held", ir, 32'h0043_0804);

        // Misaligned word load
        xfer("lw13", 1'b0, SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, bn, mis);
`ifdef MISALIGN_TRAP_EN
        check_val("lw13_mis", {31'b0, mis}, 32'd1);
        check_val("lw13_mdr", mdr, 32'hFFFF_BEEF);
`else
        check_val("lw13_mis", {31'b0, mis}, 32'd0);
        check_val("lw13_mdr", mdr, 32'hDEAD_BEEF);
`endif

        // Address wrap
        xfer("st104", 1'b1, SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h1122_3344, bn, mis);
        xfer("lw04", 1'b0, SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h04, 32'h0, bn, mis);
        check_val("wrap_lw04", mdr, 32'h1122_3344);
        xfer("lw00", 1'b0, SZ_WORD, 1'b0, 1'b1, 1'b0, 32'h00, 32'h0, bn, mis);
        check_val("wrap_lw00", mdr, 32'h0043_0804);

        // Requests while busy are dropped
        @(negedge clk);
        mem_we = 1'b0; mem_size = SZ_WORD; iord = 1'b1; alu_out = 32'h10; mem_req = 1'b1;
        @(posedge clk); #1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_done) dones++;
            if (i == 1) mem_req = 1'b0;
            @(posedge clk); #1;
        end
        check_val("busy_req_dones", 32'(dones), 32'd1);
        check_val("busy_req_mdr", mdr, 32'hDEAD_BEEF);

        // Reset during a pending store
        @(negedge clk); pc_we = 1'b1; pc_next = 32'h0000_0040;
        @(negedge clk); pc_we = 1'b0;
        check_val("pc_we", pc, 32'h0000_0040);
        xfer("sb20a", 1'b1, SZ_BYTE, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0000_0011, bn, mis);
        @(negedge clk);
        mem_we = 1'b1; mem_size = SZ_BYTE; iord = 1'b1; alu_out = 32'h20; wdata = 32'h0000_005A; mem_req = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_pc",  pc,  32'h0);
        check_val("abort_ir",  ir,  32'h0);
        check_val("abort_mdr", mdr, 32'h0);
        check_val("abort_flags", {29'b0, mem_busy, mem_done, misalign}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        xfer("lb20", 1'b0, SZ_BYTE, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, bn, mis);
        check_val("abort_mem", mdr, 32'h0000_0011);

        // PC update during an in-flight fetch
        @(negedge clk);
        mem_we = 1'b0; mem_size = SZ_WORD; iord = 1'b0; ir_we = 1'b1; mem_req = 1'b1;
        @(posedge clk); #1;
        mem_req = 1'b0; ir_we = 1'b0; pc_we = 1'b1; pc_next = 32'h0000_0004;
        @(posedge clk); #1;
        pc_we = 1'b0;
        check_val("pc_midfetch", pc, 32'h0000_0004);
        lat = 2;
        while (!mem_done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("midfetch_lat", 32'(lat), 32'd3);
        @(posedge clk); #1;
        check_val("midfetch_ir", ir, 32'h0043_0804);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
